// File: rtl/fir_ctrl_pkg.sv
// Shared encodings for the FIR sequencing controller: ALU ops, FSM states and
// the "no register" address.
package fir_ctrl_pkg;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_COPY  = 3'b001;
   localparam logic [2:0] OP_LOAD1 = 3'b010;
   localparam logic [2:0] OP_LOAD2 = 3'b011;
   localparam logic [2:0] OP_ADD   = 3'b100;
   localparam logic [2:0] OP_SUB   = 3'b101;
   localparam logic [2:0] OP_MUL   = 3'b110;

   typedef enum logic [3:0] {
      IDLE,
      LOAD_C,
      WAIT_C,
      LOAD_D,
      ZERO,
      SHIFT,
      MUL,
      ACC,
      EIDLE
   } state_t;

   // All-ones address; users slice the low REG_ADDR_W bits.
   localparam logic [31:0] NOREG = '1;

endpackage

// File: rtl/fir_seq_controller_tap_counter.sv
// Tap index counter shared by coefficient load, history shift and MAC loops.
module fir_tap_counter #(
   parameter int NUM_TAPS = 4,
   parameter int IDX_W    = 2
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clr,
   input  logic             inc,
   output logic [IDX_W-1:0] idx,
   output logic             last
);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         idx <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (inc) begin
         idx <= idx + IDX_W'(1);
      end
   end

   assign last = (idx == IDX_W'(NUM_TAPS - 1));

endmodule

// File: rtl/fir_seq_controller.sv
// Sequencing FSM for the FIR datapath: loads coefficients, shifts the sample
// history and runs one MUL/ACC pair per tap.
module fir_seq_controller
   import fir_ctrl_pkg::*;
#(
   parameter int                  NUM_TAPS        = 4,
   parameter int                  REG_ADDR_W      = 4,
   parameter logic [NUM_TAPS-1:0] COEFF_SIGN_MASK = 4'b1010
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  dr,
   input  logic                  lc,
   input  logic                  overflow,
   output logic                  cnt_up,
   output logic                  clear,
   output logic                  modwait,
   output logic [2:0]            op,
   output logic [REG_ADDR_W-1:0] src1,
   output logic [REG_ADDR_W-1:0] src2,
   output logic [REG_ADDR_W-1:0] dest,
   output logic                  err,
   output logic                  coeff_loaded,
   output logic                  done,
   output logic [3:0]            dbg_state
);

   localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam logic [REG_ADDR_W-1:0] NO_REG = NOREG[REG_ADDR_W-1:0];
   localparam int unsigned SAMPLE_NEW = NUM_TAPS + 1;
   localparam int unsigned COEFF_BASE = NUM_TAPS + 2;
   localparam int unsigned COEFF_LAST = 2 * NUM_TAPS + 1;
   localparam int unsigned TEMP_REG   = 2 * NUM_TAPS + 2;

   state_t            state;
   state_t            next_state;
   logic [IDX_W-1:0]  idx;
   logic              idx_last;
   logic              idx_clr;
   logic              idx_inc;
   logic              cl_set;
   logic              cl_clr;
   int unsigned       idx_i;

   function automatic logic [REG_ADDR_W-1:0] ra(input int unsigned v);
      return REG_ADDR_W'(v);
   endfunction

   fir_tap_counter #(
      .NUM_TAPS (NUM_TAPS),
      .IDX_W    (IDX_W)
   ) u_tap_counter (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (idx_clr),
      .inc   (idx_inc),
      .idx   (idx),
      .last  (idx_last)
   );

   assign idx_i     = 32'(idx);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= IDLE;
         coeff_loaded <= 1'b0;
      end else begin
         state <= next_state;
         if (cl_clr) begin
            coeff_loaded <= 1'b0;
         end else if (cl_set) begin
            coeff_loaded <= 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      cnt_up     = 1'b0;
      clear      = 1'b0;
      modwait    = 1'b0;
      op         = OP_NOP;
      src1       = NO_REG;
      src2       = NO_REG;
      dest       = NO_REG;
      err        = 1'b0;
      done       = 1'b0;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      cl_set     = 1'b0;
      cl_clr     = 1'b0;

      case (state)
         IDLE: begin
            if (dr) begin
               next_state = coeff_loaded ? LOAD_D : EIDLE;
            end else if (lc) begin
               next_state = LOAD_C;
               idx_clr    = 1'b1;
               cl_clr     = 1'b1;
            end
         end
         LOAD_C: begin
            clear   = 1'b1;
            op      = OP_LOAD2;
            dest    = ra(COEFF_BASE + idx_i);
            modwait = 1'b1;
            if (idx_last) begin
               next_state = IDLE;
               cl_set     = 1'b1;
               idx_clr    = 1'b1;
            end else begin
               next_state = WAIT_C;
               idx_inc    = 1'b1;
            end
         end
         WAIT_C: begin
            if (lc) begin
               next_state = LOAD_C;
            end
         end
         LOAD_D: begin
            cnt_up     = 1'b1;
            op         = OP_LOAD1;
            dest       = ra(SAMPLE_NEW);
            next_state = dr ? ZERO : EIDLE;
         end
         ZERO: begin
            op         = OP_SUB;
            src1       = ra(0);
            src2       = ra(0);
            dest       = ra(0);
            modwait    = 1'b1;
            next_state = SHIFT;
            idx_clr    = 1'b1;
         end
         SHIFT: begin
            // History moves down one slot per cycle, oldest slot first.
            op      = OP_COPY;
            src1    = ra(idx_i + 2);
            dest    = ra(idx_i + 1);
            modwait = 1'b1;
            if (idx_last) begin
               next_state = MUL;
               idx_clr    = 1'b1;
            end else begin
               idx_inc    = 1'b1;
            end
         end
         MUL: begin
            // Oldest sample pairs with the last coefficient register.
            op         = OP_MUL;
            src1       = ra(idx_i + 1);
            src2       = ra(COEFF_LAST - idx_i);
            dest       = ra(TEMP_REG);
            modwait    = 1'b1;
            next_state = ACC;
         end
         ACC: begin
            op      = COEFF_SIGN_MASK[idx] ? OP_SUB : OP_ADD;
            src1    = ra(0);
            src2    = ra(TEMP_REG);
            dest    = ra(0);
            modwait = 1'b1;
            if (overflow) begin
               next_state = EIDLE;
               idx_clr    = 1'b1;
            end else if (idx_last) begin
               next_state = IDLE;
               done       = 1'b1;
               idx_clr    = 1'b1;
            end else begin
               next_state = MUL;
               idx_inc    = 1'b1;
            end
         end
         EIDLE: begin
            err = 1'b1;
            if (dr) begin
               next_state = LOAD_D;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fir_seq_controller.sv
// Bench for fir_seq_controller: a 4-tap (mask 1010) and a 6-tap (mask 0) instance.
module tb_fir_seq_controller;

   localparam int W = 21;
   localparam logic [2:0] E_NOP = 3'b000, E_COPY = 3'b001, E_LOAD1 = 3'b010, E_LOAD2 = 3'b011;
   localparam logic [2:0] E_ADD = 3'b100, E_SUB = 3'b101, E_MUL = 3'b110;
   localparam int NR = 15;

   logic clk = 1'b0;
   logic n_rst;
   logic [1:0] dr, lc, ovf;
   logic [1:0] cnt_up_v, clear_v, modwait_v, err_v, cl_v, done_v;
   logic [2:0] op_v [2];
   logic [3:0] src1_v [2];
   logic [3:0] src2_v [2];
   logic [3:0] dest_v [2];
   logic [3:0] dbg_v [2];

   int       n_of [2] = '{4, 6};
   logic [5:0] mask_of [2] = '{6'b001010, 6'b000000};
   bit [1:0] cl_m;

   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];

   int checks = 0;
   int fails = 0;
   int req_seq = 0;
   int req_done = 0;
   int req_dut;
   int req_kind;
   logic [W-1:0] req_exp;
   string req_name;

   always #5 clk = ~clk;

   fir_seq_controller #(.NUM_TAPS(4), .REG_ADDR_W(4), .COEFF_SIGN_MASK(4'b1010)) u_dut4 (
      .clk(clk), .n_rst(n_rst), .dr(dr[0]), .lc(lc[0]), .overflow(ovf[0]),
      .cnt_up(cnt_up_v[0]), .clear(clear_v[0]), .modwait(modwait_v[0]), .op(op_v[0]),
      .src1(src1_v[0]), .src2(src2_v[0]), .dest(dest_v[0]), .err(err_v[0]),
      .coeff_loaded(cl_v[0]), .done(done_v[0]), .dbg_state(dbg_v[0])
   );

   fir_seq_controller #(.NUM_TAPS(6), .REG_ADDR_W(4), .COEFF_SIGN_MASK(6'b000000)) u_dut6 (
      .clk(clk), .n_rst(n_rst), .dr(dr[1]), .lc(lc[1]), .overflow(ovf[1]),
      .cnt_up(cnt_up_v[1]), .clear(clear_v[1]), .modwait(modwait_v[1]), .op(op_v[1]),
      .src1(src1_v[1]), .src2(src2_v[1]), .dest(dest_v[1]), .err(err_v[1]),
      .coeff_loaded(cl_v[1]), .done(done_v[1]), .dbg_state(dbg_v[1])
   );

   // ---------------- model helpers ----------------
   function automatic logic [W-1:0] mk(input bit cu, input bit clr, input bit mw, input logic [2:0] o,
                                       input int s1, input int s2, input int dst,
                                       input bit e, input bit c, input bit dn);
      return {cu, clr, mw, o, 4'(s1), 4'(s2), 4'(dst), e, c, dn};
   endfunction

   function automatic logic [W-1:0] def_w(input bit c);
      return mk(0, 0, 0, E_NOP, NR, NR, NR, 0, c, 0);
   endfunction

   function automatic logic [W-1:0] err_w(input bit c);
      return mk(0, 0, 0, E_NOP, NR, NR, NR, 1, c, 0);
   endfunction

   function automatic logic [W-1:0] actual(input int d);
      return {cnt_up_v[d], clear_v[d], modwait_v[d], op_v[d], src1_v[d], src2_v[d], dest_v[d],
              err_v[d], cl_v[d], done_v[d]};
   endfunction

   function automatic bit presenting(input int d);
      return (op_v[d] != E_NOP) || cnt_up_v[d] || clear_v[d] || modwait_v[d] || err_v[d] ||
             done_v[d] || (src1_v[d] != 4'(NR)) || (src2_v[d] != 4'(NR)) || (dest_v[d] != 4'(NR));
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   task automatic push(input int d, input logic [W-1:0] w);
      if (d == 0) exp_q0.push_back(w);
      else        exp_q1.push_back(w);
   endtask

   function automatic logic [W-1:0] pop(input int d);
      return (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [W-1:0] w;
      if (n_rst) begin
         for (int d = 0; d < 2; d++) begin
            if (presenting(d)) begin
               checks++;
               if (qsize(d) == 0) begin
                  fails++;
                  $display("FAIL unexpected_word dut%0d: got %h (state %0d), required no activity",
                           d, actual(d), dbg_v[d]);
               end else begin
                  w = pop(d);
                  if (actual(d) !== w) begin
                     fails++;
                     $display("FAIL ctrl_word dut%0d: got %h (state %0d), required %h",
                              d, actual(d), dbg_v[d], w);
                  end
               end
            end
         end
      end
      if (req_seq != req_done) begin
         req_done = req_seq;
         checks++;
         if (req_kind == 0) begin
            if (actual(req_dut) !== req_exp) begin
               fails++;
               $display("FAIL %s dut%0d: got %h, required %h", req_name, req_dut, actual(req_dut), req_exp);
            end
         end else if (qsize(req_dut) != 0) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d words outstanding, required 0", req_name, req_dut, qsize(req_dut));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_now(input int d, input int kind, input logic [W-1:0] e, input string name);
      req_dut  = d;
      req_kind = kind;
      req_exp  = e;
      req_name = name;
      req_seq++;
      @(negedge clk);
      #1;
   endtask

   task automatic rnd_inputs(input int d);
      dr[d]  = 1'($urandom_range(0, 1));
      lc[d]  = 1'($urandom_range(0, 1));
      ovf[d] = 1'($urandom_range(0, 1));
   endtask

   task automatic load_coeffs(input int d);
      int n;
      n = n_of[d];
      cl_m[d] = 1'b0;
      for (int k = 0; k < n; k++) begin
         lc[d] = 1'b1;
         push(d, mk(0, 1, 1, E_LOAD2, NR, NR, n + 2 + k, 0, 0, 0));
         tick();
         lc[d] = 1'b0;
         for (int g = 0; g < 3; g++) begin
            tick();
            dr[d] = (k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         tick();
         dr[d] = 1'b0;
      end
      cl_m[d] = 1'b1;
      check_now(d, 0, def_w(1), "coeff_loaded_idle");
   endtask

   task automatic eidle_wait(input int d, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         push(d, err_w(cl_m[d]));
         tick();
      end
   endtask

   task automatic dr_unloaded(input int d);
      dr[d] = 1'b1;
      tick();
      dr[d] = 1'b0;
   endtask

   // One sample from IDLE or EIDLE. ovf_k: ACC tap that overflows (-1 none);
   // abort_j: SHIFT step (1..n) at which reset is pulsed (-1 none).
   task automatic sample(input int d, input bit in_eidle, input bit drop, input int ovf_k, input int abort_j);
      int n;
      bit c;
      bit stop;
      bit aborted;
      n = n_of[d];
      c = cl_m[d];
      stop = 1'b0;
      aborted = 1'b0;
      dr[d] = 1'b1;
      lc[d] = 1'($urandom_range(0, 1));
      if (in_eidle) push(d, err_w(c));
      tick();
      lc[d] = 1'b0;
      push(d, mk(1, 0, 0, E_LOAD1, NR, NR, n + 1, 0, c, 0));
      if (drop) begin
         dr[d] = 1'b0;
         tick();
      end else begin
         tick();
         rnd_inputs(d);
         push(d, mk(0, 0, 1, E_SUB, 0, 0, 0, 0, c, 0));
         for (int j = 1; j <= n; j++) begin
            if (!stop) begin
               tick();
               if (j == abort_j) begin
                  n_rst = 1'b0;
                  dr = '0; lc = '0; ovf = '0;
                  check_now(d, 0, def_w(0), "reset_mid_shift");
                  stop = 1'b1;
                  aborted = 1'b1;
               end else begin
                  rnd_inputs(d);
                  push(d, mk(0, 0, 1, E_COPY, j + 1, NR, j, 0, c, 0));
               end
            end
         end
         for (int k = 0; k < n; k++) begin
            if (!stop) begin
               tick();
               rnd_inputs(d);
               push(d, mk(0, 0, 1, E_MUL, k + 1, 2 * n + 1 - k, 2 * n + 2, 0, c, 0));
               tick();
               rnd_inputs(d);
               ovf[d] = (k == ovf_k);
               push(d, mk(0, 0, 1, mask_of[d][k] ? E_SUB : E_ADD, 0, 2 * n + 2, 0, 0, c,
                          (k == n - 1) && (k != ovf_k)));
               if (k == ovf_k) stop = 1'b1;
            end
         end
         tick();
         if (aborted) begin
            n_rst = 1'b1;
            cl_m = '0;
         end
         dr[d] = 1'b0;
         lc[d] = 1'b0;
         ovf[d] = 1'b0;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_rst = 1'b0;
      dr = '0; lc = '0; ovf = '0;
      cl_m = '0;
      repeat (2) @(posedge clk);
      #1;
      check_now(0, 0, def_w(0), "reset_state_dut4");
      tick();
      n_rst = 1'b1;
      tick();
      check_now(1, 0, def_w(0), "reset_state_dut6");

      // dr with no coefficients -> error, restart from error, reset mid-SHIFT
      dr_unloaded(0);
      eidle_wait(0, 2);
      sample(0, 1, 0, -1, 2);
      check_now(0, 0, def_w(0), "idle_after_abort");

      load_coeffs(0);
      sample(0, 0, 0, -1, -1);
      sample(0, 0, 1, -1, -1);
      eidle_wait(0, 2);
      sample(0, 1, 0, -1, -1);
      sample(0, 0, 0, 1, -1);
      eidle_wait(0, 1);
      sample(0, 1, 0, -1, -1);

      for (int it = 0; it < 12; it++) begin
         int sc;
         sc = $urandom_range(0, 3);
         repeat ($urandom_range(0, 2)) tick();
         case (sc)
            0: sample(0, 0, 0, -1, -1);
            1: begin
               sample(0, 0, 1, -1, -1);
               eidle_wait(0, $urandom_range(0, 3));
               sample(0, 1, 0, -1, -1);
            end
            2: begin
               sample(0, 0, 0, $urandom_range(0, 3), -1);
               eidle_wait(0, $urandom_range(0, 3));
               sample(0, 1, 0, -1, -1);
            end
            default: load_coeffs(0);
         endcase
      end

      load_coeffs(1);
      sample(1, 0, 0, -1, -1);
      sample(1, 0, 0, $urandom_range(0, 5), -1);
      eidle_wait(1, 2);
      sample(1, 1, 0, -1, -1);

      repeat (3) tick();
      check_now(0, 1, '0, "queue_drained");
      check_now(1, 1, '0, "queue_drained");
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/fir_seq_controller.md
Name: fir_seq_controller

Overview:
- Parametrised sequencing controller for the AHB-Lite FIR filter accelerator datapath: register file, ALU and sample counter.
- Supports NUM_TAPS taps. Each tap's add/subtract is selected by a sign mask.
- Loads coefficients through an index counter, with no unrolled states per coefficient.
- Flags use of the filter before all coefficients are loaded. Emits a one-cycle done indication when a sample completes.

Parameters:
- NUM_TAPS, 4: number of FIR taps. Must satisfy 2*NUM_TAPS+2 <= 2**REG_ADDR_W - 2.
- REG_ADDR_W, 4: register-file address width. The all-ones address means "no register".
- COEFF_SIGN_MASK, 4'b1010 (NUM_TAPS bits): bit k=1 means tap k's product is subtracted from the accumulator; bit k=0 means it is added.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- dr  in  1  new sample data ready.
- lc  in  1  load coefficient request.
- overflow  in  1  ALU overflow from the current op.
- cnt_up  out  1  sample counter increment.
- clear  out  1  sample counter clear.
- modwait  out  1  datapath busy.
- op  out  3  ALU op: NOP=000, COPY=001, LOAD1=010, LOAD2=011, ADD=100, SUB=101, MUL=110.
- src1  out  REG_ADDR_W  source register 1.
- src2  out  REG_ADDR_W  source register 2.
- dest  out  REG_ADDR_W  destination register.
- err  out  1  error state indicator.
- coeff_loaded  out  1  all NUM_TAPS coefficients are valid.
- done  out  1  sample result valid in register 0.

Behaviour:
- Register map (defaults shown for N=NUM_TAPS=4):
  - R0: accumulator.
  - R1..RN: sample history, oldest at R1.
  - R(N+1): new sample.
  - R(N+2)..R(2N+1): coefficients F0..F(N-1).
  - R(2N+2): product temp.
  - Defaults: samples 1-4, new sample 5, coefficients 6-9, temp 10.
- State register and tap index idx (clog2(NUM_TAPS) bits) are both reset asynchronously: state=IDLE, idx=0, coeff_loaded=0.
- All outputs are Moore-decoded from state/idx, except done.
- Defaults in every state: cnt_up=0, clear=0, op=NOP, src1/src2/dest=all-ones, err=0, modwait=0, done=0. These are also the reset values.
- IDLE:
  - dr has priority over lc.
  - dr with coeff_loaded=1 -> LOAD_D.
  - dr with coeff_loaded=0 -> EIDLE.
  - lc -> LOAD_C with idx=0, and coeff_loaded cleared.
- LOAD_C:
  - Outputs: clear=1, op=LOAD2, dest=N+2+idx, modwait=1.
  - If idx==N-1 -> IDLE, set coeff_loaded, idx=0.
  - Otherwise -> WAIT_C, idx++.
- WAIT_C: lc -> LOAD_C. dr is ignored while waiting.
- LOAD_D:
  - Outputs: cnt_up=1, op=LOAD1, dest=N+1, modwait=0.
  - dr=0 -> EIDLE; otherwise -> ZERO.
- ZERO: op=SUB, src1=src2=dest=0, modwait=1 -> SHIFT, idx=0.
- SHIFT:
  - Outputs: op=COPY, src1=idx+2, dest=idx+1, modwait=1.
  - idx==N-1 -> MUL, idx=0; otherwise idx++.
- MUL: op=MUL, src1=idx+1, src2=2N+1-idx, dest=2N+2, modwait=1 -> ACC.
- ACC:
  - Outputs: op = SUB if COEFF_SIGN_MASK[idx] else ADD; src1=0, src2=2N+2, dest=0, modwait=1.
  - overflow=1 -> EIDLE, idx=0. This takes priority over done.
  - Else if idx==N-1 -> IDLE with done=1 (combinational, this cycle only).
  - Else -> MUL, idx++.
- EIDLE: err=1. dr -> LOAD_D; coeff_loaded is retained.
- Sample latency from LOAD_D entry to the done cycle: 3N+2 cycles (14 for N=4).
- lc and dr are ignored during the processing states (ZERO, SHIFT, MUL, ACC).
- Reset asserted mid-operation aborts immediately to IDLE. Coefficients must then be reloaded (coeff_loaded=0).

Decomposition:
- Package fir_ctrl_pkg holds:
  - the op encodings as localparams,
  - the state_t enum (IDLE, LOAD_C, WAIT_C, LOAD_D, ZERO, SHIFT, MUL, ACC, EIDLE),
  - the NOREG constant.
- One sub-module, fir_tap_counter: the idx counter with load-zero, increment and terminal-count (idx==NUM_TAPS-1) output.

Test Plan:
- Reset check: reset, then 4 lc pulses each separated by 3 idle cycles -> LOAD_C dest=6,7,8,9 with clear=1, op=011, modwait=1; coeff_loaded rises after the 4th.
- Normal sample: dr held 2 cycles after load ->
  - LOAD_D: dest=5, cnt_up=1.
  - ZERO.
  - COPY 2->1, 3->2, 4->3, 5->4.
  - MUL/ACC sequence ADD, SUB, ADD, SUB with MUL src2=9,8,7,6.
  - done=1 on cycle 14.
- dr drops after 1 cycle in LOAD_D -> EIDLE with err=1. A subsequent dr restarts from LOAD_D with err=0.
- overflow=1 during the second ACC (SUB) -> EIDLE next cycle, no done pulse, idx=0.
- dr before any coefficient load -> EIDLE with err=1. Assert n_rst low mid-SHIFT -> all outputs return to default values immediately.
- NUM_TAPS=6, COEFF_SIGN_MASK=6'b000000 -> coefficient destinations 8..13, temp=14, 6 ADDs, done after 20 cycles.
